// File: rtl/divider_nonrestoring.sv
// rtl/divider_nonrestoring.sv - sequential non-restoring divider, one quotient bit per clock; DIVIDER_SIGNED_EN selects two's complement operands
module divider_nonrestoring #(
    parameter int data_length = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [data_length-1:0] dividend,
    input  logic [data_length-1:0] divisor,
    output logic [data_length-1:0] quotient,
    output logic [data_length-1:0] remainder,
    output logic                   ready,
    output logic                   div_by_zero,
    output logic                   ovf
);
    localparam int N  = data_length;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {IDLE, PREP, ITER, CORRECT, DONE} state_t;

    state_t        state;
    logic [N-1:0]  dvd_r;      // captured dividend (raw bits)
    logic [N-1:0]  dvs_r;      // captured divisor (raw bits)
    logic [N-1:0]  d_r;        // divisor magnitude used by the iterations
    logic [N:0]    rem_r;      // signed partial remainder
    logic [N-1:0]  q_r;        // dividend shifting out / quotient shifting in
    logic [CW-1:0] count;

    logic [N:0]    r_shift;
    logic [N:0]    r_next;
    logic [N-1:0]  q_next;
    logic [N:0]    r_fix;
    logic [N-1:0]  dvd_mag;
    logic [N-1:0]  dvs_mag;
    logic [N-1:0]  q_out;
    logic [N-1:0]  rem_out;
    logic          ovf_calc;

    // One non-restoring step: shift {R,Q}, add or subtract D by the old sign, record ~sign.
    // Intermediates may wrap in N+1 bits; the post-step value always lies in [-D, D).
    always_comb begin
        r_shift = {rem_r[N-1:0], q_r[N-1]};
        if (rem_r[N])
            r_next = r_shift + {1'b0, d_r};
        else
            r_next = r_shift - {1'b0, d_r};
        q_next = {q_r[N-2:0], ~r_next[N]};
        r_fix  = rem_r[N] ? (rem_r + {1'b0, d_r}) : rem_r;
    end

    // Operand magnitudes and final sign application; unsigned build passes raw values through.
    always_comb begin
`ifdef DIVIDER_SIGNED_EN
        dvd_mag  = dvd_r[N-1] ? (-dvd_r) : dvd_r;
        dvs_mag  = dvs_r[N-1] ? (-dvs_r) : dvs_r;
        q_out    = (dvd_r[N-1] ^ dvs_r[N-1]) ? (-q_r) : q_r;
        rem_out  = dvd_r[N-1] ? (-r_fix[N-1:0]) : r_fix[N-1:0];
        ovf_calc = (dvd_r == {1'b1, {(N-1){1'b0}}}) && (dvs_r == {N{1'b1}});
`else
        dvd_mag  = dvd_r;
        dvs_mag  = dvs_r;
        q_out    = q_r;
        rem_out  = r_fix[N-1:0];
        ovf_calc = 1'b0;
`endif
    end

    // Control FSM with registered results and a one-cycle ready pulse on entry to DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            dvd_r       <= '0;
            dvs_r       <= '0;
            d_r         <= '0;
            rem_r       <= '0;
            q_r         <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            ready       <= 1'b0;
            div_by_zero <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_r       <= dividend;
                        dvs_r       <= divisor;
                        div_by_zero <= 1'b0;
                        ovf         <= 1'b0;
                        state       <= PREP;
                    end
                end
                PREP: begin
                    if (dvs_r == '0) begin
                        quotient    <= '1;
                        remainder   <= dvd_r;
                        div_by_zero <= 1'b1;
                        ovf         <= 1'b0;
                        ready       <= 1'b1;
                        state       <= DONE;
                    end else begin
                        d_r   <= dvs_mag;
                        q_r   <= dvd_mag;
                        rem_r <= '0;
                        count <= '0;
                        state <= ITER;
                    end
                end
                ITER: begin
                    rem_r <= r_next;
                    q_r   <= q_next;
                    count <= count + 1'b1;
                    if (count == LAST)
                        state <= CORRECT;
                end
                CORRECT: begin
                    quotient    <= q_out;
                    remainder   <= rem_out;
                    ovf         <= ovf_calc;
                    div_by_zero <= 1'b0;
                    ready       <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_divider_nonrestoring.sv
// tb/tb_divider_nonrestoring.sv - self-checking bench for divider_nonrestoring (follows DIVIDER_SIGNED_EN)
module tb_divider_nonrestoring;
    localparam int N = 6;

    logic         clock;
    logic         reset;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         ready;
    logic         div_by_zero;
    logic         ovf;

    divider_nonrestoring #(.data_length(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .ready       (ready),
        .div_by_zero (div_by_zero),
        .ovf         (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         ov;
    } vec_t;

    vec_t tbl[$];
    int   n_vec;
    int   n_err;

    logic [N-1:0] got_q, got_r;
    logic         got_dz, got_ov;
    int           got_lat;
    int           pulses, first_rdy;
    logic [13:0]  exp_all;
    logic [11:0]  idx;
    int           perm_mul, perm_off;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [N-1:0] a, b, q, r, input logic dz, ov);
        vec_t v;
        v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz; v.ov = ov;
        return v;
    endfunction

    // Reference: plain integer division; returns {quotient, remainder, div_by_zero, ovf}
    function automatic logic [13:0] ref_div(input logic [N-1:0] a, b);
        int sa, sb, qi, ri;
        logic [N-1:0] q, r;
        logic dz, ov;
        dz = 1'b0; ov = 1'b0;
        if (b == 0) begin
            q = '1; r = a; dz = 1'b1;
        end else begin
`ifdef DIVIDER_SIGNED_EN
            sa = $signed(a);
            sb = $signed(b);
            if (sa == -32 && sb == -1) begin
                ov = 1'b1;
                qi = -32;
                ri = 0;
            end else begin
                qi = sa / sb;
                ri = sa % sb;
            end
`else
            sa = int'(a);
            sb = int'(b);
            qi = sa / sb;
            ri = sa % sb;
`endif
            q = qi[N-1:0];
            r = ri[N-1:0];
        end
        return {q, r, dz, ov};
    endfunction

    // Issue one division from a negedge; returns results sampled at the ready pulse and its cycle count
    task automatic run_div(input logic [N-1:0] a, b,
                           output logic [N-1:0] q, r, output logic dz, ov, output int lat);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock);
        lat = 0;
        q = 'x; r = 'x; dz = 1'bx; ov = 1'bx;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clock);
            start    = 1'b0;
            dividend = ~a;
            divisor  = ~b;
            if (ready) begin
                lat = c;
                q = quotient; r = remainder; dz = div_by_zero; ov = ovf;
            end
        end
        if (lat == 0)
            $display("FAIL timeout: ready not seen for %0d/%0d", a, b);
        @(negedge clock);
        check("ready_single_pulse", 32'(ready), 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor  = '0;

`ifdef DIVIDER_SIGNED_EN
        tbl.push_back(mk(6'd27,      6'd5,       6'd5,       6'd2,       1'b0, 1'b0));
        tbl.push_back(mk(6'b100101,  6'd5,       6'b111011,  6'b111110,  1'b0, 1'b0));
        tbl.push_back(mk(6'd27,      6'b111011,  6'b111011,  6'd2,       1'b0, 1'b0));
        tbl.push_back(mk(6'b100101,  6'b111011,  6'd5,       6'b111110,  1'b0, 1'b0));
        tbl.push_back(mk(6'd13,      6'd0,       6'b111111,  6'b001101,  1'b1, 1'b0));
        tbl.push_back(mk(6'd20,      6'd3,       6'd6,       6'd2,       1'b0, 1'b0));
        tbl.push_back(mk(6'b100000,  6'b111111,  6'b100000,  6'd0,       1'b0, 1'b1));
        tbl.push_back(mk(6'b100000,  6'd7,       6'b111100,  6'b111100,  1'b0, 1'b0));
        tbl.push_back(mk(6'd31,      6'b100000,  6'd0,       6'd31,      1'b0, 1'b0));
        tbl.push_back(mk(6'b111111,  6'd1,       6'b111111,  6'd0,       1'b0, 1'b0));
`else
        tbl.push_back(mk(6'd27,      6'd5,       6'd5,       6'd2,       1'b0, 1'b0));
        tbl.push_back(mk(6'd13,      6'd0,       6'b111111,  6'b001101,  1'b1, 1'b0));
        tbl.push_back(mk(6'd20,      6'd3,       6'd6,       6'd2,       1'b0, 1'b0));
        tbl.push_back(mk(6'd37,      6'd5,       6'd7,       6'd2,       1'b0, 1'b0));
        tbl.push_back(mk(6'd32,      6'd63,      6'd0,       6'd32,      1'b0, 1'b0));
        tbl.push_back(mk(6'd63,      6'd1,       6'd63,      6'd0,       1'b0, 1'b0));
        tbl.push_back(mk(6'd32,      6'd7,       6'd4,       6'd4,       1'b0, 1'b0));
        tbl.push_back(mk(6'd63,      6'd63,      6'd1,       6'd0,       1'b0, 1'b0));
        tbl.push_back(mk(6'd0,       6'd5,       6'd0,       6'd0,       1'b0, 1'b0));
`endif

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_outputs", {26'd0, quotient, remainder, ready, div_by_zero, ovf}, 32'd0);
        reset = 1'b0;

        // Table: consecutive entries run back-to-back (start issued in the first IDLE cycle)
        foreach (tbl[i]) begin
            run_div(tbl[i].a, tbl[i].b, got_q, got_r, got_dz, got_ov, got_lat);
            check($sformatf("tbl%0d_result", i), {18'd0, got_q, got_r, got_dz, got_ov},
                  {18'd0, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ov});
            check($sformatf("tbl%0d_latency", i), 32'(got_lat), tbl[i].dz ? 32'd2 : 32'd9);
        end

        // start pulsed mid-iteration with other operands must be ignored
        dividend = 6'd27; divisor = 6'd5; start = 1'b1;
        @(posedge clock);
        pulses = 0; first_rdy = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clock);
            start = (c == 4);
            if (c == 4) begin dividend = 6'd50; divisor = 6'd3; end
            if (ready) begin
                pulses++;
                if (first_rdy == 0) begin
                    first_rdy = c; got_q = quotient; got_r = remainder;
                end
            end
        end
        check("ignored_start_pulses", 32'(pulses), 32'd1);
        check("ignored_start_latency", 32'(first_rdy), 32'd9);
        check("ignored_start_result", {20'd0, got_q, got_r}, {20'd0, 6'd5, 6'd2});

        // Reset during ITER cycle 3 clears everything and suppresses ready
        dividend = 6'd20; divisor = 6'd3; start = 1'b1;
        @(posedge clock);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_reset_outputs", {26'd0, quotient, remainder, ready, div_by_zero, ovf}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clock);
            if (ready) pulses++;
        end
        check("mid_reset_no_ready", 32'(pulses), 32'd0);
        run_div(6'd20, 6'd3, got_q, got_r, got_dz, got_ov, got_lat);
        check("after_reset_result", {18'd0, got_q, got_r, got_dz, got_ov}, {18'd0, 6'd6, 6'd2, 1'b0, 1'b0});
        check("after_reset_latency", 32'(got_lat), 32'd9);

        // Every operand pair, visited in a random permutation order
        perm_mul = int'($urandom & 32'hFFF) | 1;
        perm_off = int'($urandom & 32'hFFF);
        for (int i = 0; i < 4096; i++) begin
            idx = 12'(i * perm_mul + perm_off);
            exp_all = ref_div(idx[11:6], idx[5:0]);
            run_div(idx[11:6], idx[5:0], got_q, got_r, got_dz, got_ov, got_lat);
            check($sformatf("sweep %0d/%0d result", idx[11:6], idx[5:0]),
                  {18'd0, got_q, got_r, got_dz, got_ov}, {18'd0, exp_all});
            check($sformatf("sweep %0d/%0d latency", idx[11:6], idx[5:0]),
                  32'(got_lat), (idx[5:0] == 6'd0) ? 32'd2 : 32'd9);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
